fb_swap_ctrl: RTL and testbench
===============================

FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 360, pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 360, lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 17, framebuffer address width; SHALL satisfy 2**ADDR_W >= WIDTH*HEIGHT.
REQ-004 SHALL have port clk_in, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port vsync_in, input, 1, one-cycle pulse at display frame boundary.
REQ-007 SHALL have port raster_done_in, input, 1, one-cycle pulse when the rasterizer has finished the back buffer.
REQ-008 SHALL have port buffer_sel, output, 1, buffer being displayed; writes target the other buffer.
REQ-009 SHALL have port clear_we, output, 1, clear-engine write enable to the back buffer.
REQ-010 SHALL have port clear_addr, output, ADDR_W, clear-engine write address.
REQ-011 SHALL have port clear_data, output, 16, clear word: constant 16'h00FF (black colour, max depth).
REQ-012 SHALL have port raster_en, output, 1, rasterizer may write the back buffer.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse when rendering of a new frame may begin.
REQ-014 SHALL have port frame_count, output, 8, number of completed swaps; wraps 255->0.
REQ-015 SHALL have port drop_count, output, 16, vsync pulses that could not swap (see REQ-030).

Function
REQ-016 SHALL implement states CLEAR, RENDER, WAIT_SWAP.
REQ-017 In CLEAR, SHALL assert clear_we with clear_addr counting 0..WIDTH*HEIGHT-1, one address per cycle, exactly WIDTH*HEIGHT cycles.
REQ-018 SHALL, on the cycle clear_addr = WIDTH*HEIGHT-1 is written, transition CLEAR->RENDER; clear_we SHALL be low on the next cycle.
REQ-019 SHALL pulse frame_start for exactly the first cycle in RENDER.
REQ-020 SHALL hold raster_en high in RENDER only; clear_we and raster_en SHALL never both be high.
REQ-021 In RENDER, raster_done_in SHALL transition to WAIT_SWAP.
REQ-022 In WAIT_SWAP, vsync_in SHALL toggle buffer_sel, increment frame_count, reset clear_addr to 0 and transition to CLEAR.
REQ-023 In RENDER, raster_done_in and vsync_in on the same cycle SHALL swap immediately as REQ-022 (skip WAIT_SWAP).
REQ-024 buffer_sel SHALL change only on a swap; clear_addr SHALL be 0 whenever clear_we is low.
REQ-025 raster_done_in outside RENDER SHALL be ignored.
REQ-026 All outputs SHALL be registered; zero combinational paths input->output.

Reset
REQ-027 While rst_in high: state CLEAR, clear_addr 0, buffer_sel 0, frame_count 0, drop_count 0, frame_start 0, raster_en 0, clear_we 0.
REQ-028 On rst_in release, SHALL begin clearing on the first clock edge (clear_we high in the cycle after that edge), clearing buffer 1.
REQ-029 rst_in asserted mid-clear or mid-render SHALL abort immediately; the clear restarts from address 0 after release.

Configuration
REQ-030 With FB_SWAP_STATS_EN defined, drop_count SHALL increment (saturating at 16'hFFFF) for each vsync_in in CLEAR or in RENDER without simultaneous raster_done_in; without it, drop_count SHALL be constant 0 and no counter logic synthesized.

Structure
REQ-031 Package fb_pkg SHALL hold the state enum fb_state_t, CLEAR_WORD = 16'h00FF and the address width helper.
REQ-032 Address counter SHALL be sub-module fb_clear_counter (start, count, last flag); the FSM stays in fb_swap_ctrl.

Verification (WIDTH=4, HEIGHT=2)
REQ-033 Release reset -> clear_we high 8 cycles, addr 0..7, then frame_start single pulse, raster_en 1, buffer_sel 0.
REQ-034 raster_done_in in RENDER, vsync_in 5 cycles later -> buffer_sel 1, frame_count 1, 8-cycle clear restarts at addr 0.
REQ-035 raster_done_in and vsync_in same RENDER cycle -> immediate swap, WAIT_SWAP never entered.
REQ-036 vsync_in during CLEAR, then during RENDER -> no swap, drop_count 2 (macro on) / 0 (macro off).
REQ-037 rst_in asserted at clear_addr 5 -> outputs reset asynchronously, clear restarts at 0 after release.
REQ-038 256 swaps -> frame_count wraps to 0; buffer_sel toggles each swap; clear_we and raster_en never both high.

Source files
------------

// File: rtl/fb_pkg.sv
// ============================================================================
// fb_pkg : shared types and constants for the framebuffer swap controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    RENDER    = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_state_t;

  localparam logic [15:0] CLEAR_WORD = 16'h00FF;

  // Minimum address width able to index 'depth' words.
  function automatic int unsigned fb_addr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fb_clear_counter.sv
// ============================================================================
// fb_clear_counter : back-buffer clear address sequencer (0..WIDTH*HEIGHT-1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_clear_counter
  import fb_pkg::*;
#(
  parameter int WIDTH  = 360,
  parameter int HEIGHT = 360,
  parameter int ADDR_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_i,
  output logic              active_o,
  output logic [ADDR_W-1:0] count_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  logic              active_q, active_d;
  logic [ADDR_W-1:0] count_q,  count_d;

  // The count parks at zero whenever the sequencer is idle.
  always_comb begin
    active_d = active_q;
    count_d  = count_q;
    if (start_i) begin
      active_d = 1'b1;
      count_d  = '0;
    end else if (active_q) begin
      if (count_q == c_LAST) begin
        active_d = 1'b0;
        count_d  = '0;
      end else begin
        count_d = count_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      active_q <= 1'b0;
      count_q  <= '0;
    end else begin
      active_q <= active_d;
      count_q  <= count_d;
    end
  end

  assign active_o = active_q;
  assign count_o  = count_q;
  assign last_o   = active_q && (count_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/fb_swap_ctrl.sv
// ============================================================================
// fb_swap_ctrl : double-buffer clear/render/swap sequencer.
// Optional macro FB_SWAP_STATS_EN enables the saturating dropped-vsync counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_swap_ctrl
  import fb_pkg::*;
#(
  parameter int WIDTH  = 360,
  parameter int HEIGHT = 360,
  parameter int ADDR_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              vsync_in,
  input  logic              raster_done_in,
  output logic              buffer_sel,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic [15:0]       clear_data,
  output logic              raster_en,
  output logic              frame_start,
  output logic [7:0]        frame_count,
  output logic [15:0]       drop_count
);

  fb_state_t   state_q, state_d;
  logic        buffer_sel_q, buffer_sel_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic        raster_en_q, raster_en_d;
  logic        frame_start_q, frame_start_d;
  logic        w_start;
  logic        w_swap;
  logic        w_clr_active;
  logic        w_clr_last;

  fb_clear_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_clear_counter (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_i  (w_start),
    .active_o (w_clr_active),
    .count_o  (clear_addr),
    .last_o   (w_clr_last)
  );

  // A swap launches the next clear on the same edge, so CLEAR with an idle
  // counter only occurs in the first cycle after reset release.
  always_comb begin
    state_d = state_q;
    w_start = 1'b0;
    w_swap  = 1'b0;
    case (state_q)
      CLEAR: begin
        if (!w_clr_active) begin
          w_start = 1'b1;
        end else if (w_clr_last) begin
          state_d = RENDER;
        end
      end
      RENDER: begin
        if (raster_done_in && vsync_in) begin
          w_swap = 1'b1;
        end else if (raster_done_in) begin
          state_d = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        if (vsync_in) begin
          w_swap = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
    if (w_swap) begin
      state_d = CLEAR;
      w_start = 1'b1;
    end
    buffer_sel_d  = buffer_sel_q ^ w_swap;
    frame_count_d = frame_count_q + {7'd0, w_swap};
    raster_en_d   = (state_d == RENDER);
    frame_start_d = (state_d == RENDER) && (state_q != RENDER);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= CLEAR;
      buffer_sel_q  <= 1'b0;
      frame_count_q <= 8'd0;
      raster_en_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buffer_sel_q  <= buffer_sel_d;
      frame_count_q <= frame_count_d;
      raster_en_q   <= raster_en_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef FB_SWAP_STATS_EN
  logic        w_drop;
  logic [15:0] drop_q, drop_d;

  assign w_drop = vsync_in &&
                  ((state_q == CLEAR) || ((state_q == RENDER) && !raster_done_in));

  always_comb begin
    drop_d = drop_q;
    if (w_drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_q <= 16'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 16'd0;
`endif

  assign buffer_sel  = buffer_sel_q;
  assign clear_we    = w_clr_active;
  assign clear_data  = CLEAR_WORD;
  assign raster_en   = raster_en_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_swap_ctrl.sv
// ============================================================================
// tb_fb_swap_ctrl : directed bench for fb_swap_ctrl (WIDTH=4, HEIGHT=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_swap_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;
  localparam int N  = W * H;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          vsync_in;
  logic          raster_done_in;
  logic          buffer_sel;
  logic          clear_we;
  logic [AW-1:0] clear_addr;
  logic [15:0]   clear_data;
  logic          raster_en;
  logic          frame_start;
  logic [7:0]    frame_count;
  logic [15:0]   drop_count;

  int n_pass  = 0;
  int n_total = 0;

  fb_swap_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .vsync_in       (vsync_in),
    .raster_done_in (raster_done_in),
    .buffer_sel     (buffer_sel),
    .clear_we       (clear_we),
    .clear_addr     (clear_addr),
    .clear_data     (clear_data),
    .raster_en      (raster_en),
    .frame_start    (frame_start),
    .frame_count    (frame_count),
    .drop_count     (drop_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: phase 0 clearing, 1 rendering, 2 waiting for vsync.
  int m_phase, m_we, m_addr, m_rc, m_sel, m_frames, m_drops;
  bit m_swap;

  function automatic int bump_drop(input int d);
`ifdef FB_SWAP_STATS_EN
    return (d < 65535) ? d + 1 : d;
`else
    return d;
`endif
  endfunction

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_phase = 0; m_we = 0; m_addr = 0; m_rc = 0;
      m_sel = 0; m_frames = 0; m_drops = 0;
    end else begin
      m_swap = 1'b0;
      if (m_phase == 0) begin
        if (vsync_in) m_drops = bump_drop(m_drops);
        if (m_we == 0) begin
          m_we = 1; m_addr = 0;
        end else if (m_addr == N - 1) begin
          m_we = 0; m_addr = 0; m_phase = 1; m_rc = 0;
        end else begin
          m_addr = m_addr + 1;
        end
      end else if (m_phase == 1) begin
        m_rc = m_rc + 1;
        if (raster_done_in && vsync_in) m_swap = 1'b1;
        else if (raster_done_in)         m_phase = 2;
        else if (vsync_in)               m_drops = bump_drop(m_drops);
      end else if (vsync_in) begin
        m_swap = 1'b1;
      end
      if (m_swap) begin
        m_phase = 0; m_we = 1; m_addr = 0;
        m_sel = m_sel ^ 1; m_frames = (m_frames + 1) % 256;
      end
    end
  end

  always @(negedge clk_in) begin
    chk("clear_we",    clear_we,    m_we);
    chk("clear_addr",  clear_addr,  m_addr);
    chk("clear_data",  clear_data,  32'h00FF);
    chk("raster_en",   raster_en,   (m_phase == 1) ? 1 : 0);
    chk("frame_start", frame_start, (m_phase == 1 && m_rc == 0) ? 1 : 0);
    chk("buffer_sel",  buffer_sel,  m_sel);
    chk("frame_count", frame_count, m_frames);
    chk("drop_count",  drop_count,  m_drops);
    chk("we_en_excl",  clear_we & raster_en, 0);
  end

  task automatic tk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pulse(input logic rd, input logic vs);
    raster_done_in = rd;
    vsync_in       = vs;
    tk(1);
    raster_done_in = 1'b0;
    vsync_in       = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; vsync_in = 1'b0; raster_done_in = 1'b0;
    tk(3);
    chk("lit_rst_we", clear_we, 0);
    chk("lit_rst_fs", frame_start, 0);
    rst_in = 1'b0;
    tk(1);
    chk("lit_first_we",   clear_we, 1);
    chk("lit_first_addr", clear_addr, 0);
    tk(7);
    chk("lit_last_addr",  clear_addr, 7);
    tk(1);
    chk("lit_fs_pulse",   frame_start, 1);
    chk("lit_ren",        raster_en, 1);
    chk("lit_we_off",     clear_we, 0);
    chk("lit_sel0",       buffer_sel, 0);
    tk(1);
    chk("lit_fs_single",  frame_start, 0);

    // Done, then vsync five cycles later.
    pulse(1'b1, 1'b0);
    tk(4);
    pulse(1'b0, 1'b1);
    chk("lit_swap_sel",   buffer_sel, 1);
    chk("lit_swap_fc",    frame_count, 1);
    chk("lit_swap_addr0", clear_addr, 0);
    chk("lit_swap_we",    clear_we, 1);
    tk(8);
    chk("lit_fs_again",   frame_start, 1);

    // Simultaneous done+vsync: immediate swap.
    pulse(1'b1, 1'b1);
    chk("lit_imm_sel", buffer_sel, 0);
    chk("lit_imm_fc",  frame_count, 2);

    // vsync (and ignored done) in CLEAR, then a lone vsync in RENDER.
    tk(2);
    pulse(1'b1, 1'b1);
    chk("lit_clr_noswap", frame_count, 2);
    chk("lit_clr_addr",   clear_addr, 3);
    tk(5);
    chk("lit_fs_3",       frame_start, 1);
    pulse(1'b0, 1'b1);
    chk("lit_ren_noswap", raster_en, 1);
    chk("lit_ren_sel",    buffer_sel, 0);
`ifdef FB_SWAP_STATS_EN
    chk("lit_drops", drop_count, 2);
`else
    chk("lit_drops", drop_count, 0);
`endif

    // Extra done while waiting is ignored; vsync swaps.
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    tk(2);
    pulse(1'b0, 1'b1);
    chk("lit_wait_fc", frame_count, 3);
    tk(5);
    chk("lit_mid_addr", clear_addr, 5);

    // Asynchronous reset mid-clear.
    #2 rst_in = 1'b1;
    #1;
    chk("lit_arst_we",   clear_we, 0);
    chk("lit_arst_addr", clear_addr, 0);
    chk("lit_arst_sel",  buffer_sel, 0);
    chk("lit_arst_fc",   frame_count, 0);
    chk("lit_arst_drop", drop_count, 0);
    tk(2);
    rst_in = 1'b0;
    tk(1);
    chk("lit_restart_addr", clear_addr, 0);
    chk("lit_restart_we",   clear_we, 1);
    tk(8);
    chk("lit_restart_fs",   frame_start, 1);

    // 256 swaps, alternating immediate and deferred paths.
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) begin
        pulse(1'b1, 1'b1);
      end else begin
        pulse(1'b1, 1'b0);
        tk(1);
        pulse(1'b0, 1'b1);
      end
      chk("lit_loop_sel", buffer_sel, (i + 1) % 2);
      tk(8);
    end
    chk("lit_wrap_fc",  frame_count, 0);
    chk("lit_wrap_sel", buffer_sel, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
